// File: rtl/add_share_sched.sv
// add_share_sched: time-shares one 35-bit + 12-bit adder (36-bit result)
// between NREQ requesters. It arbitrates, captures the winner's operands,
// performs the add, and holds the result under a valid/ready handshake.
// Each requester owns a 35-bit running-sum accumulator with a sticky overflow flag.
//
// Build option:
//   ADD_SHARE_SCHED_RR_EN  defined     -> round-robin arbitration
//                          not defined -> fixed priority, lowest index wins

module add_share_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*35-1:0]   req_a,
    input  logic [NREQ*12-1:0]   req_b,
    input  logic [NREQ-1:0]      req_acc,
    input  logic [NREQ-1:0]      acc_clr,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [35:0]          res_sum,
    output logic [IDW-1:0]       res_id,
    output logic [NREQ-1:0]      acc_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Arbitration results for the current cycle
    logic            grant_en;
    logic            grant_any;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [34:0]     a_sel;
    logic [11:0]     b_sel;

    // Operands captured at the handshake, consumed in ADD
    logic [34:0]     a_q;
    logic [11:0]     b_q;
    logic [IDW-1:0]  id_q;

    // The shared adder; the 36-bit result never wraps
    logic [35:0]     sum;

    // Per-requester running sums
    logic [34:0]     acc [NREQ];

    // Arbitration search start (round-robin pointer, or constant 0)
    logic [IDW-1:0]  ptr;

    // Grants are only offered when the adder pipeline can take a new operand pair:
    // in IDLE, or in RESP in the same cycle the current result is consumed.
    assign grant_en = (state == ST_IDLE) || ((state == ST_RESP) && res_ready);

    // Combinational arbiter: search from ptr upward with wrap, first requester wins.
    always_comb begin : arb
        int idx;
        // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        a_sel     = '0;
        b_sel     = '0;
        idx       = 0;
        if (grant_en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!grant_any && req_valid[idx]) begin
                    grant_any   = 1'b1;
                    grant[idx]  = 1'b1;
                    grant_id    = IDW'(idx);
                    a_sel       = req_acc[idx] ? acc[idx] : req_a[35*idx +: 35];
                    b_sel       = req_b[12*idx +: 12];
                end
            end
        end
    end

    assign req_ready = grant;

`ifdef ADD_SHARE_SCHED_RR_EN
    // Round-robin pointer: after a grant to i, the next search starts at i+1 (mod NREQ).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        end
    end
`else
    // Fixed priority: the search always starts at requester 0.
    assign ptr = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> ADD on grant, ADD -> RESP, RESP -> ADD/IDLE on consume
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_nxt = grant_any ? ST_ADD : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture on every handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            id_q <= '0;
        end else if (grant_any) begin
            a_q  <= a_sel;
            b_q  <= b_sel;
            id_q <= grant_id;
        end
    end

    assign sum = {1'b0, a_q} + {24'd0, b_q};

    // Result register: loaded in ADD, held until the consumer accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
        end else if (state == ST_ADD) begin
            res_valid <= 1'b1;
            res_sum   <= sum;
            res_id    <= id_q;
        end else if ((state == ST_RESP) && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Accumulators: updated with the truncated sum on ADD->RESP; a clear on the same index wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the accumulator array is small and must start at zero, so it is reset like ordinary flops.
            for (int i = 0; i < NREQ; i++) begin
                acc[i] <= '0;
            end
            acc_ovf <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc_clr[i]) begin
                    acc[i]     <= '0;
                    acc_ovf[i] <= 1'b0;
                end else if ((state == ST_ADD) && (id_q == IDW'(i))) begin
                    acc[i]     <= sum[34:0];
                    acc_ovf[i] <= acc_ovf[i] | sum[35];
                end
            end
        end
    end

endmodule

// File: tb/tb_add_share_sched.sv
// Self-checking bench for add_share_sched. A transaction-level reference model
// (winner selection, arithmetic sum, accumulator array) predicts every result.
// Build option ADD_SHARE_SCHED_RR_EN selects the expected arbitration rule.

module tb_add_share_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 3;
    localparam longint unsigned TWO35 = 64'h8_0000_0000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*35-1:0]   req_a = '0;
    logic [NREQ*12-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_acc = '0;
    logic [NREQ-1:0]      acc_clr = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [35:0]          res_sum;
    logic [IDW-1:0]       res_id;
    logic [NREQ-1:0]      acc_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint unsigned m_acc [NREQ];
    bit              m_ovf [NREQ];
    int              m_ptr;

    always #5 clk = ~clk;

    add_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_acc   (req_acc),
        .acc_clr   (acc_clr),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .acc_ovf   (acc_ovf)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
        end
        m_ptr = 0;
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v);
`ifdef ADD_SHARE_SCHED_RR_EN
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic model_grant(input int w);
        m_ptr = (w + 1) % NREQ;
    endtask

    function automatic logic [35:0] model_sum(input int w, input logic [34:0] a,
                                              input logic [11:0] b, input logic use_acc);
        longint unsigned base;
        base = use_acc ? m_acc[w] : longint'(a);
        return 36'(base + longint'(b));
    endfunction

    task automatic model_clear(input logic [NREQ-1:0] clr);
        for (int i = 0; i < NREQ; i++) begin
            if (clr[i]) begin
                m_acc[i] = 0;
                m_ovf[i] = 0;
            end
        end
    endtask

    task automatic model_commit(input int w, input logic [35:0] s, input logic [NREQ-1:0] clr);
        longint unsigned sv;
        sv = longint'(s);
        for (int i = 0; i < NREQ; i++) begin
            if (clr[i]) begin
                m_acc[i] = 0;
                m_ovf[i] = 0;
            end else if (i == w) begin
                if (sv >= TWO35) begin
                    m_acc[i] = sv - TWO35;
                    m_ovf[i] = 1;
                end else begin
                    m_acc[i] = sv;
                end
            end
        end
    endtask

    function automatic logic [NREQ-1:0] ovf_vec();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        req_valid = '0; req_acc = '0; acc_clr = '0; res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One complete transaction from IDLE; clr_cap is driven in the handshake cycle,
    // clr_add in the add cycle, and the result is held for 'hold' cycles first.
    task automatic do_txn(input logic [NREQ-1:0] v, input logic [NREQ*35-1:0] a,
                          input logic [NREQ*12-1:0] b, input logic [NREQ-1:0] accf,
                          input int hold, input logic [NREQ-1:0] clr_cap,
                          input logic [NREQ-1:0] clr_add);
        int              w;
        logic [35:0]     es;
        logic [NREQ-1:0] eg;
        w  = model_pick(v);
        es = model_sum(w, a[35*w +: 35], b[12*w +: 12], accf[w]);
        eg = '0;
        eg[w] = 1'b1;
        req_valid = v; req_a = a; req_b = b; req_acc = accf; acc_clr = clr_cap; res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== eg) begin
            errors++;
            $display("FAIL txn_grant: req_ready got %b want %b", req_ready, eg);
        end
        @(posedge clk); #1;
        model_grant(w);
        model_clear(clr_cap);
        req_valid = '0; acc_clr = clr_add;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL txn_add_phase: res_valid %b req_ready %b want 0 and 0", res_valid, req_ready);
        end
        @(posedge clk); #1;
        acc_clr = '0;
        model_commit(w, es, clr_add);
        for (int h = 0; h <= hold; h++) begin
            res_ready = (h == hold);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_sum !== es || res_id !== IDW'(w) || req_ready !== '0) begin
                errors++;
                $display("FAIL txn_result: valid %b sum %h id %0d rdy %b want 1 %h %0d 0",
                         res_valid, res_sum, res_id, req_ready, es, w);
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || acc_ovf !== ovf_vec()) begin
            errors++;
            $display("FAIL txn_after: valid %b ovf %b want 0 %b", res_valid, acc_ovf, ovf_vec());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b0 || res_sum !== '0 || res_id !== '0 || acc_ovf !== '0) begin
            errors++;
            $display("FAIL reset_held: rdy %b valid %b sum %h id %0d ovf %b want all 0",
                     req_ready, res_valid, res_sum, res_id, acc_ovf);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b0 || res_sum !== '0 || acc_ovf !== '0) begin
            errors++;
            $display("FAIL reset_release: rdy %b valid %b sum %h ovf %b want all 0",
                     req_ready, res_valid, res_sum, acc_ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [NREQ*35-1:0] a;
        logic [NREQ*12-1:0] b;
        a = '0; b = '0;
        a[35*2 +: 35] = 35'h000001000;
        b[12*2 +: 12] = 12'hFFF;
        do_txn(4'b0100, a, b, 4'b0000, 0, '0, '0);
    endtask

    task automatic test_contention();
        int          w;
        int          pw;
        logic [35:0] es;
        logic [35:0] pes;
        logic [NREQ-1:0] eg;
        logic [NREQ*35-1:0] a;
        logic [NREQ*12-1:0] b;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a[35*i +: 35] = 35'({$urandom(), $urandom()});
            b[12*i +: 12] = 12'($urandom());
        end
        req_a = a; req_b = b; req_acc = '0; req_valid = '1; res_ready = 1'b1;
        pw = 0; pes = '0;
        for (int g = 0; g < 5; g++) begin
            w  = model_pick(4'b1111);
            es = model_sum(w, a[35*w +: 35], b[12*w +: 12], 1'b0);
            eg = '0;
            eg[w] = 1'b1;
            @(negedge clk);
            checks++;
            if (req_ready !== eg) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b want %b", g, req_ready, eg);
            end
            if (g > 0) begin
                checks++;
                if (res_valid !== 1'b1 || res_sum !== pes || res_id !== IDW'(pw)) begin
                    errors++;
                    $display("FAIL contention_result%0d: valid %b sum %h id %0d want 1 %h %0d",
                             g, res_valid, res_sum, res_id, pes, pw);
                end
            end
            @(posedge clk); #1;
            model_grant(w);
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL contention_gap%0d: rdy %b valid %b want 0 0", g, req_ready, res_valid);
            end
            @(posedge clk); #1;
            model_commit(w, es, '0);
            pw = w; pes = es;
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_sum !== pes || res_id !== IDW'(pw)) begin
            errors++;
            $display("FAIL contention_last: valid %b sum %h id %0d want 1 %h %0d",
                     res_valid, res_sum, res_id, pes, pw);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL contention_drain: valid %b want 0", res_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [35:0] es1;
        logic [35:0] es3;
        logic [NREQ*35-1:0] a;
        logic [NREQ*12-1:0] b;
        for (int i = 0; i < NREQ; i++) begin
            a[35*i +: 35] = 35'({$urandom(), $urandom()});
            b[12*i +: 12] = 12'($urandom());
        end
        req_a = a; req_b = b; req_acc = '0; res_ready = 1'b0;
        es1 = model_sum(1, a[35*1 +: 35], b[12*1 +: 12], 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant1: got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        model_grant(1);
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_add: rdy %b valid %b want 0 0", req_ready, res_valid);
        end
        @(posedge clk); #1;
        model_commit(1, es1, '0);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_sum !== es1 || res_id !== IDW'(1) || req_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid %b sum %h id %0d rdy %b want 1 %h 1 0",
                         h, res_valid, res_sum, res_id, req_ready, es1);
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        es3 = model_sum(3, a[35*3 +: 35], b[12*3 +: 12], 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000 || res_valid !== 1'b1 || res_sum !== es1) begin
            errors++;
            $display("FAIL bp_release: rdy %b valid %b sum %h want 1000 1 %h", req_ready, res_valid, res_sum, es1);
        end
        @(posedge clk); #1;
        model_grant(3);
        req_valid = '0; res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_add: valid %b want 0", res_valid);
        end
        @(posedge clk); #1;
        model_commit(3, es3, '0);
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_sum !== es3 || res_id !== IDW'(3)) begin
            errors++;
            $display("FAIL bp_second_result: valid %b sum %h id %0d want 1 %h 3", res_valid, res_sum, res_id, es3);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid %b want 0", res_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_accumulate();
        logic [NREQ*35-1:0] a;
        logic [NREQ*12-1:0] b;
        a = '0; b = '0;
        b[12*1 +: 12] = 12'h800;
        acc_clr = 4'b0010;
        @(posedge clk); #1;
        acc_clr = '0;
        model_clear(4'b0010);
        for (int n = 0; n < 3; n++) begin
            do_txn(4'b0010, a, b, 4'b0010, 0, '0, '0);
        end
        checks++;
        if (m_acc[1] != 64'h1800) begin
            errors++;
            $display("FAIL acc_chain: model acc %h want 1800", m_acc[1]);
        end
    endtask

    task automatic test_overflow();
        logic [NREQ*35-1:0] a;
        logic [NREQ*12-1:0] b;
        a = '0; b = '0;
        a[34:0] = 35'h7FFFFFFFF;
        b[11:0] = 12'h001;
        do_txn(4'b0001, a, b, 4'b0000, 1, '0, '0);
        checks++;
        if (acc_ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: acc_ovf[0] %b want 1", acc_ovf[0]);
        end
        // Reading the accumulator back through an add of zero shows it truncated to 0
        b[11:0] = 12'h000;
        do_txn(4'b0001, a, b, 4'b0001, 0, '0, '0);
        // Overflowing update with a coincident clear: the clear wins
        b[11:0] = 12'h001;
        do_txn(4'b0001, a, b, 4'b0000, 0, '0, 4'b0001);
        checks++;
        if (acc_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear_wins: acc_ovf[0] %b want 0", acc_ovf[0]);
        end
        b[11:0] = 12'h005;
        do_txn(4'b0001, a, b, 4'b0001, 0, '0, '0);
    endtask

    task automatic test_reset_in_add();
        logic [NREQ*35-1:0] a;
        logic [NREQ*12-1:0] b;
        a = '0; b = '0;
        a[35*3 +: 35] = 35'h7FFFFFFFF;
        b[12*3 +: 12] = 12'hFFF;
        do_txn(4'b1000, a, b, 4'b0000, 0, '0, '0);
        a[35*2 +: 35] = 35'h123456789;
        req_a = a; req_b = b; req_acc = '0;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b0 || res_sum !== '0 || res_id !== '0 || acc_ovf !== '0) begin
            errors++;
            $display("FAIL reset_async: rdy %b valid %b sum %h id %0d ovf %b want all 0",
                     req_ready, res_valid, res_sum, res_id, acc_ovf);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_result%0d: valid %b want 0", h, res_valid);
            end
            @(posedge clk); #1;
        end
        b[12*2 +: 12] = 12'h00A;
        do_txn(4'b0100, a, b, 4'b0000, 0, '0, '0);
    endtask

    task automatic test_random();
        logic [NREQ-1:0]    v;
        logic [NREQ*35-1:0] a;
        logic [NREQ*12-1:0] b;
        logic [NREQ-1:0]    accf;
        logic [NREQ-1:0]    cc;
        logic [NREQ-1:0]    ca;
        logic [63:0]        r;
        for (int n = 0; n < 40; n++) begin
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                r = {$urandom(), $urandom()};
                a[35*i +: 35] = ($urandom_range(0, 5) == 0) ? 35'h7FFFFFFFF : r[34:0];
                b[12*i +: 12] = 12'($urandom());
            end
            accf = NREQ'($urandom());
            cc   = ($urandom_range(0, 5) == 0) ? NREQ'($urandom()) : '0;
            ca   = ($urandom_range(0, 5) == 0) ? NREQ'($urandom()) : '0;
            do_txn(v, a, b, accf, $urandom_range(0, 3), cc, ca);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_accumulate();
        test_overflow();
        test_reset_in_add();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_share_sched.md
# add_share_sched

Scheduler that time-shares one unsigned 35-bit + 12-bit adder (36-bit result) between `NREQ` requesters. It arbitrates among requests, captures the winner's operands, sequences the add, and holds the result under a valid/ready handshake. Per-requester 35-bit accumulators support running-sum use, such as partial-product accumulation in the multiplier path. It sits between the datapath stages that issue offset/partial-sum additions and the shared adder instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, 3: width of `res_id`; must satisfy 2^IDW >= NREQ.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request strobe, one bit per requester.
- `req_ready`  out  NREQ  one-hot grant; the handshake completes when `req_valid[i] & req_ready[i]`.
- `req_a`  in  NREQ*35  A operand; requester i uses slice [35i+34:35i].
- `req_b`  in  NREQ*12  B operand; requester i uses slice [12i+11:12i]; zero-extended to 35 bits.
- `req_acc`  in  NREQ  when set, A is taken from accumulator i instead of `req_a`.
- `acc_clr`  in  NREQ  synchronous clear of accumulator i and overflow i.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  36  A + zext(B).
- `res_id`  out  IDW  index of the requester that owns `res_sum`.
- `acc_ovf`  out  NREQ  sticky overflow per accumulator.

## Operation
- FSM states:
  - IDLE: `req_ready` = grant vector when any `req_valid` is set. On a handshake, capture A (accumulator i if `req_acc[i]`, else `req_a` slice i), B, and id, then go to ADD.
  - ADD: drive the adder from the captured operands. Register `res_sum` and `res_id`, set `res_valid`, then go to RESP.
  - RESP: hold all outputs stable until `res_ready`.
    - With `res_ready` and a pending request: grant and capture in the same cycle, then go to ADD.
    - With `res_ready` and no pending request: go to IDLE.
- `req_ready` is zero in ADD, and zero in RESP while `res_ready` = 0.
- Grant is combinational from `req_valid`, the state, and the priority pointer. At most one bit is set.
- Accumulator update happens on the ADD→RESP edge for requester id:
  - `acc[id]` <= `sum[34:0]`.
  - `acc_ovf[id]` |= `sum[35]`.
  - This update happens for every completed request, whether or not `req_acc` was set.
- `acc_clr[i]` clears `acc[i]` and `acc_ovf[i]`. If it coincides with an update to the same i, the clear wins.
- `acc_clr` asserted during the capture cycle does not alter the already-captured A.
- Width rules: unsigned arithmetic only. The 36-bit sum never wraps. Only the accumulator truncates to 35 bits.

## Timing
- Reset values:
  - state IDLE, `req_ready` = 0, `res_valid` = 0, `res_sum` = 0, `res_id` = 0.
  - All accumulators = 0, `acc_ovf` = 0, priority pointer = 0.
- Latency: a handshake in cycle n gives `res_valid` = 1 in cycle n+2.
- Throughput: one result per 2 cycles when `res_ready` is held high.
- Backpressure: `res_sum` and `res_id` are stable while `res_valid & !res_ready`. No grants are issued during that time.
- Reset mid-operation: the in-flight request is discarded without a result. The requester must re-issue.
- Requesters may drop `req_valid` without being granted. There is no obligation on them.

## Configuration
- `ADD_SHARE_SCHED_RR_EN` defined: round-robin arbitration.
  - The search starts at pointer p, ascending with wrap.
  - After a grant to i, p <= (i+1) mod NREQ.
  - Any continuously requesting requester is granted within NREQ grants.
- Not defined: fixed priority, lowest index wins. The pointer is absent or constant 0.

## Test plan
- Single request: requester 2, A = 35'h000001000, B = 12'hFFF, `res_ready` = 1.
  - Expected: `req_ready` = 4'b0100 in cycle 0.
  - Expected: `res_valid` in cycle 2, with `res_sum` = 36'h000001FFF and `res_id` = 2.
- Contention, all four requesting continuously, `res_ready` = 1:
  - RR_EN: grant order 0,1,2,3,0.
  - Without RR_EN: 0,0,0.
  - One grant every 2 cycles in both cases.
- Backpressure: hold `res_ready` = 0 for 5 cycles after `res_valid`.
  - Expected: outputs stable and `req_ready` = 0 throughout.
  - Expected: on the `res_ready` cycle a pending request is granted and its result appears 2 cycles later.
- Accumulate on requester 1:
  - `acc_clr[1]`, then three requests with `req_acc` = 1 and B = 12'h800.
  - Expected sums: 36'h800, 36'h1000, 36'h1800, each with `res_id` = 1.
- Overflow on requester 0: `req_a` = 35'h7FFFFFFFF, B = 12'h001.
  - Expected: `res_sum` = 36'h800000000, `acc[0]` = 0, `acc_ovf[0]` = 1.
  - Then `acc_clr[0]` in the same cycle as an update to requester 0: the clear wins, giving acc 0 and ovf 0.
- Reset asserted in ADD:
  - Expected: all outputs return to reset values asynchronously and no result is emitted.
  - Expected: after release, a new request completes normally.
